zrle_stream_encoder: RTL and testbench
======================================

Name: zrle_stream_encoder

Overview:
- Parametrised zero-run-length encoder for the compression datapath, operating on a valid/ready byte stream.
- Input symbols are buffered in an internal FIFO.
- Non-zero symbols pass through unchanged. Each run of zeros is replaced by the pair {0x00 marker, run count}.
- Frame-aware: a run is terminated and flushed at in_last. Output backpressure is honoured with no symbol loss.

Parameters:
- DATA_W, 8, symbol width in bits; the count word has the same width.
- FIFO_DEPTH, 16, input FIFO entries; power of two, >= 2.
- MAX_RUN, 255, largest count emitted in one pair; 1 <= MAX_RUN <= 2**DATA_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input symbol valid.
- in_ready  out  1  FIFO not full; the symbol is accepted when in_valid && in_ready.
- in_data  in  DATA_W  input symbol.
- in_last  in  1  final symbol of the frame.
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts; a transfer occurs when out_valid && out_ready.
- out_data  out  DATA_W  encoded word (literal, marker or count).
- out_last  out  1  final encoded word of the frame.
- run_active  out  1  an unflushed zero run is in progress (status).
- fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to S_DATA and the FIFO empties.
  - in_ready=0 while reset is held; in_ready=1 from the first clk edge after release.
  - out_valid=0, out_data=0, out_last=0, run_active=0, fifo_level=0, run_cnt=0.
  - Reset mid-frame discards buffered symbols and any partial run; no flush pair is emitted.
- FIFO:
  - Write on the input handshake; the encoder pops the head.
  - Simultaneous push and pop when full is not permitted, because in_ready=0 when full.
  - Push and pop in the same cycle when non-empty leaves the level unchanged.
- Output slot:
  - A single registered output word. It is loadable when !out_valid || out_ready.
  - out_data and out_last hold stable while out_valid && !out_ready.
- States:
  - S_DATA:
    - Head non-zero and slot loadable: emit head, out_last = head.last, pop.
    - Head zero: pop, run_cnt=1, run_last=head.last. If head.last or MAX_RUN==1, go S_MARK; otherwise go S_RUN. No output this cycle.
  - S_RUN:
    - Head zero and run_cnt<MAX_RUN: pop, run_cnt++, run_last=head.last. Go S_MARK if head.last or run_cnt+1==MAX_RUN; otherwise stay.
    - Head non-zero: go S_MARK without popping; the head is kept for later.
    - FIFO empty: stay in S_RUN. There is no timeout, so a run stays open until a non-zero symbol, in_last or MAX_RUN.
  - S_MARK: when the slot is loadable, emit 0x00 with out_last=0, then go S_CNT.
  - S_CNT: when the slot is loadable, emit run_cnt with out_last=run_last. Clear run_cnt and run_last, then go S_DATA.
- Minimum latency: 2 cycles from the input handshake to out_valid (FIFO write, then output register).
- Steady-state throughput:
  - Literals: 1 word/cycle.
  - A run of N<=MAX_RUN zeros: N pop cycles plus 2 emit cycles.
- Run splitting:
  - A run longer than MAX_RUN is split into consecutive pairs {0,MAX_RUN}…{0,remainder}.
  - A count of 0 is never emitted.
- run_active=1 in S_RUN, S_MARK and S_CNT.
- Decoder contract: a 0x00 word is always followed by a non-zero count word.

Decomposition:
- Package zrle_pkg:
  - State encoding localparams S_DATA=2'd0, S_RUN=2'd1, S_MARK=2'd2, S_CNT=2'd3.
  - ZERO_MARKER constant = 0.
  - Function for the count width.
- One sub-module, zrle_sync_fifo:
  - Parameters DATA_W+1 and FIFO_DEPTH; the stored word is {last,data}.
  - Ports: push/pop/full/empty/level, using the same clk/rst.
- The encoder FSM and output register live in zrle_stream_encoder.

Test Plan:
- Literals 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out 0x11,0x22,0x33; out_last only on 0x33; first out_valid 2 cycles after the first accept.
- 0x05,0,0,0,0x07(last) -> out 0x05,0x00,0x03,0x07; out_last on 0x07.
- DATA_W=8, MAX_RUN=255: 600 zeros, last on the final zero -> 0x00,0xFF,0x00,0xFF,0x00,0x5A; out_last on 0x5A; no zero count emitted.
- Frame ends in a run: 0x09,0,0(last), then next frame 0x04 -> 0x09,0x00,0x02(last),0x04; no merge across frames.
- out_ready toggled 1/0 each cycle while 20 random symbols stream in and the FIFO fills -> in_ready=0 at level 16; output identical to the out_ready=1 run; out_data held stable while stalled.
- rst pulsed low mid-run (3 zeros popped) -> outputs reset immediately; no pair emitted; the next frame 0x01(last) -> out 0x01 with out_last.

Source files
------------

// File: rtl/zrle_pkg.sv
// Shared types and constants for the zero-run-length stream encoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package zrle_pkg;

   // Encoder FSM states
   typedef enum logic [1:0] {
      S_DATA = 2'd0,
      S_RUN  = 2'd1,
      S_MARK = 2'd2,
      S_CNT  = 2'd3
   } zrle_state_e;

   // Value emitted in front of every run count
   localparam int ZERO_MARKER = 0;

   // Width of an occupancy counter able to hold 0..depth inclusive
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/zrle_sync_fifo.sv
// Synchronous first-word-fall-through FIFO buffering {last,data} input words.
// Latency: a pushed word is visible at rdata_o the cycle after the push.
// Backpressure: full_o must gate pushes; popping while empty is ignored.
// Ports: clk/rst (async active-low), push_i/wdata_i write side,
//        pop_i/rdata_o/empty_o read side, full_o and level_o status.
module zrle_sync_fifo
   import zrle_pkg::*;
#(
   parameter int W     = 9,
   parameter int DEPTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  logic [W-1:0]              wdata_i,
   input  logic                      pop_i,
   output logic [W-1:0]              rdata_o,
   output logic                      full_o,
   output logic                      empty_o,
   output logic [level_w(DEPTH)-1:0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   // Pointers carry one wrap bit so full and empty are distinguishable
   logic [LW-1:0] wr_ptr_q, rd_ptr_q;

   logic do_push, do_pop;

   assign level_o = wr_ptr_q - rd_ptr_q;
   assign full_o  = (level_o == LW'(DEPTH));
   assign empty_o = (level_o == '0);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + LW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + LW'(1);
      end
   end

endmodule

// File: rtl/zrle_stream_encoder.sv
// Zero-run-length encoder: literals pass through, zero runs become {0x00, count}.
// Latency: 2 cycles from input handshake to out_valid (FIFO write, output register).
// Backpressure: single output register held while stalled; input FIFO absorbs the rest.
// Ports: clk/rst (async active-low); in_valid/in_ready/in_data/in_last input stream;
//        out_valid/out_ready/out_data/out_last encoded stream; run_active, fifo_level status.
module zrle_stream_encoder
   import zrle_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_RUN    = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [DATA_W-1:0]              in_data,
   input  logic                           in_last,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [DATA_W-1:0]              out_data,
   output logic                           out_last,
   output logic                           run_active,
   output logic [level_w(FIFO_DEPTH)-1:0] fifo_level
);

   localparam logic [DATA_W-1:0] MAX_RUN_C = DATA_W'(MAX_RUN);
   localparam logic [DATA_W-1:0] MARKER_C  = DATA_W'(ZERO_MARKER);

   // Input FIFO
   logic              fifo_full, fifo_empty, fifo_pop, push;
   logic [DATA_W:0]   head;
   logic [DATA_W-1:0] head_data;
   logic              head_last, head_vld, head_zero;
   logic              rdy_q;

   // in_ready stays low until the first clock edge after reset release
   assign in_ready  = rdy_q && !fifo_full;
   assign push      = in_valid && in_ready;
   assign head_data = head[DATA_W-1:0];
   assign head_last = head[DATA_W];
   assign head_vld  = !fifo_empty;
   assign head_zero = (head_data == MARKER_C);

   zrle_sync_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .wdata_i ({in_last, in_data}),
      .pop_i   (fifo_pop),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   // FSM and output register state
   zrle_state_e       state_q, state_d;
   logic [DATA_W-1:0] run_cnt_q, run_cnt_d;
   logic              run_last_q, run_last_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_last_q, out_last_d;
   logic              loadable, emit;
   logic [DATA_W-1:0] emit_data;
   logic              emit_last;

   assign loadable = !out_valid_q || out_ready;

   always_comb begin
      state_d    = state_q;
      run_cnt_d  = run_cnt_q;
      run_last_d = run_last_q;
      fifo_pop   = 1'b0;
      emit       = 1'b0;
      emit_data  = '0;
      emit_last  = 1'b0;

      unique case (state_q)
         S_DATA: begin
            if (head_vld) begin
               if (!head_zero) begin
                  if (loadable) begin
                     emit      = 1'b1;
                     emit_data = head_data;
                     emit_last = head_last;
                     fifo_pop  = 1'b1;
                  end
               end else begin
                  fifo_pop   = 1'b1;
                  run_cnt_d  = DATA_W'(1);
                  run_last_d = head_last;
                  state_d    = (head_last || MAX_RUN == 1) ? S_MARK : S_RUN;
               end
            end
         end
         S_RUN: begin
            // run_cnt_q < MAX_RUN always holds here: reaching MAX_RUN leaves S_RUN
            if (head_vld) begin
               if (head_zero) begin
                  fifo_pop   = 1'b1;
                  run_cnt_d  = run_cnt_q + DATA_W'(1);
                  run_last_d = head_last;
                  if (head_last || (run_cnt_q + DATA_W'(1) == MAX_RUN_C)) begin
                     state_d = S_MARK;
                  end
               end else begin
                  // Non-zero head terminates the run and stays queued
                  state_d = S_MARK;
               end
            end
         end
         S_MARK: begin
            if (loadable) begin
               emit      = 1'b1;
               emit_data = MARKER_C;
               emit_last = 1'b0;
               state_d   = S_CNT;
            end
         end
         S_CNT: begin
            if (loadable) begin
               emit       = 1'b1;
               emit_data  = run_cnt_q;
               emit_last  = run_last_q;
               run_cnt_d  = '0;
               run_last_d = 1'b0;
               state_d    = S_DATA;
            end
         end
         default: state_d = S_DATA;
      endcase

      out_valid_d = emit ? 1'b1      : (out_ready ? 1'b0 : out_valid_q);
      out_data_d  = emit ? emit_data : out_data_q;
      out_last_d  = emit ? emit_last : out_last_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_DATA;
         run_cnt_q   <= '0;
         run_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_cnt_q   <= run_cnt_d;
         run_last_q  <= run_last_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         rdy_q       <= 1'b1;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_last   = out_last_q;
   assign run_active = (state_q != S_DATA);

endmodule

// File: tb/tb_zrle_stream_encoder.sv
// Directed self-checking bench for zrle_stream_encoder (DATA_W=8, depth 16, MAX_RUN=255).
// Latency: n/a.
// Backpressure: exercised by holding and toggling out_ready.
module tb_zrle_stream_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, in_last;
   logic [7:0] in_data;
   logic       out_valid, out_ready, out_last;
   logic [7:0] out_data;
   logic       run_active;
   logic [4:0] fifo_level;

   int checks = 0;
   int errors = 0;

   logic [8:0] q[$];          // accepted output words {last,data}
   logic       prev_stall = 1'b0;
   logic [8:0] prev_word  = '0;

   always #5 clk = ~clk;

   zrle_stream_encoder #(
      .DATA_W     (8),
      .FIFO_DEPTH (16),
      .MAX_RUN    (255)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .run_active (run_active),
      .fifo_level (fifo_level)
   );

   // Output monitor: records transfers and checks words hold while stalled
   always @(negedge clk) begin
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!out_valid || {out_last, out_data} !== prev_word) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b word=%h, want valid=1 word=%h",
                        out_valid, {out_last, out_data}, prev_word);
            end
         end
         if (out_valid && out_ready) q.push_back({out_last, out_data});
         prev_stall = out_valid && !out_ready;
         prev_word  = {out_last, out_data};
      end
   end

   // Drive one symbol; called and returns at posedge+1
   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck low for data %h", d);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_words(input int n_words, input string name);
      int n = 0;
      while (q.size() < n_words && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (q.size() != n_words) begin
         errors++;
         $display("FAIL %s_count: got %0d words, want %0d", name, q.size(), n_words);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_data, out_last, run_active, fifo_level} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%0b vld=%0b dat=%h last=%0b run=%0b lvl=%0d, want all 0",
                  in_ready, out_valid, out_data, out_last, run_active, fifo_level);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdy_release: got %0b want 0", in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_rdy_edge: got %0b want 1", in_ready);
      end
   endtask

   task automatic test_literals();
      logic [8:0] exp [3] = '{9'h011, 9'h022, 9'h133};
      q.delete();
      send(8'h11, 1'b0);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL lat_early: out_valid got %0b want 0 one cycle after accept", out_valid);
      end
      send(8'h22, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h11) begin
         errors++;
         $display("FAIL lat_two: got vld=%0b dat=%h, want vld=1 dat=11", out_valid, out_data);
      end
      send(8'h33, 1'b1);
      wait_words(3, "literals");
      for (int i = 0; i < 3 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== exp[i]) begin
            errors++;
            $display("FAIL literals[%0d]: got %h want %h", i, q[i], exp[i]);
         end
      end
   endtask

   task automatic test_run();
      logic [8:0] exp [4] = '{9'h005, 9'h000, 9'h003, 9'h107};
      q.delete();
      send(8'h05, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h07, 1'b1);
      wait_words(4, "run");
      for (int i = 0; i < 4 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== exp[i]) begin
            errors++;
            $display("FAIL run[%0d]: got %h want %h", i, q[i], exp[i]);
         end
      end
   endtask

   task automatic test_long_run();
      logic [8:0] exp [6] = '{9'h000, 9'h0FF, 9'h000, 9'h0FF, 9'h000, 9'h15A};
      q.delete();
      for (int i = 0; i < 600; i++) send(8'h00, (i == 599));
      wait_words(6, "long_run");
      for (int i = 0; i < 6 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== exp[i]) begin
            errors++;
            $display("FAIL long_run[%0d]: got %h want %h", i, q[i], exp[i]);
         end
      end
   endtask

   task automatic test_frame_end_run();
      logic [8:0] exp [4] = '{9'h009, 9'h000, 9'h102, 9'h104};
      q.delete();
      send(8'h09, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b1);
      send(8'h04, 1'b1);
      wait_words(4, "frame_end");
      for (int i = 0; i < 4 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== exp[i]) begin
            errors++;
            $display("FAIL frame_end[%0d]: got %h want %h", i, q[i], exp[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] syms [20] = '{8'h3C, 8'hA1, 8'h00, 8'h00, 8'h5E, 8'h7F, 8'h00, 8'h12,
                                8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h9A, 8'hBC, 8'hDE,
                                8'hF0, 8'h01, 8'h02, 8'h03};
      logic [8:0] exp [20] = '{9'h03C, 9'h0A1, 9'h000, 9'h002, 9'h05E, 9'h07F, 9'h000,
                               9'h001, 9'h012, 9'h034, 9'h056, 9'h000, 9'h003, 9'h09A,
                               9'h0BC, 9'h0DE, 9'h0F0, 9'h001, 9'h002, 9'h103};
      q.delete();
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 20; i++) send(syms[i], (i == 19));
         end
         begin
            int n = 0;
            while (fifo_level != 5'd16 && n < 200) begin
               @(posedge clk); #1;
               n++;
            end
            checks++;
            if (fifo_level !== 5'd16) begin
               errors++;
               $display("FAIL bp_level: got %0d want 16", fifo_level);
            end
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL bp_full_rdy: got %0b want 0", in_ready);
            end
            n = 0;
            while (q.size() < 20 && n < 400) begin
               @(posedge clk); #1;
               out_ready = ~out_ready;
               n++;
            end
            out_ready = 1'b1;
         end
      join
      wait_words(20, "backpressure");
      for (int i = 0; i < 20 && i < q.size(); i++) begin
         checks++;
         if (q[i] !== exp[i]) begin
            errors++;
            $display("FAIL backpressure[%0d]: got %h want %h", i, q[i], exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      q.delete();
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (run_active !== 1'b1) begin
         errors++;
         $display("FAIL midrun_active: got %0b want 1", run_active);
      end
      rst = 1'b0;
      #1;
      checks++;
      if ({out_valid, out_data, out_last, run_active, fifo_level, in_ready} !== 17'd0) begin
         errors++;
         $display("FAIL midrun_reset: got vld=%0b dat=%h last=%0b run=%0b lvl=%0d rdy=%0b, want all 0",
                  out_valid, out_data, out_last, run_active, fifo_level, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      send(8'h01, 1'b1);
      wait_words(1, "midrun");
      if (q.size() > 0) begin
         checks++;
         if (q[0] !== 9'h101) begin
            errors++;
            $display("FAIL midrun_word: got %h want 101", q[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_literals();
      test_run();
      test_long_run();
      test_frame_end_run();
      test_backpressure();
      test_reset_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
